// File: rtl/nco_pkg.sv
// Shared constants for the NCO / phase-detector pair: angle and sample widths,
// the CORDIC arctangent table in 2^32-per-turn units and the inverse-gain factor.
package nco_pkg;

  localparam int ANGLE_W    = 32;
  localparam int SAMPLE_W   = 16;
  localparam int KINV       = 19898;
  localparam int KINV_SHIFT = 15;

  // ATAN_TABLE[i] = round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [0:15] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861
  };

endpackage

// File: rtl/atan_cordic_step.sv
// One combinational vectoring-CORDIC micro-rotation: drives y toward zero and
// accumulates the applied rotation into z (wrapping mod 2^32).
module atan_cordic_step
  import nco_pkg::*;
#(
  parameter int XW = 18
)(
  input  logic signed [XW-1:0]      i_x,
  input  logic signed [XW-1:0]      i_y,
  input  logic        [ANGLE_W-1:0] i_z,
  input  logic        [3:0]         i_shift,
  input  logic        [ANGLE_W-1:0] i_atan,
  output logic signed [XW-1:0]      o_x,
  output logic signed [XW-1:0]      o_y,
  output logic        [ANGLE_W-1:0] o_z
);

  logic signed [XW-1:0] w_xShr;
  logic signed [XW-1:0] w_yShr;

  assign w_xShr = i_x >>> i_shift;
  assign w_yShr = i_y >>> i_shift;

  // Both updates read the pre-step x and y.
  always_comb begin
    if (!i_y[XW-1]) begin
      o_x = i_x + w_yShr;
      o_y = i_y - w_xShr;
      o_z = i_z + i_atan;
    end else begin
      o_x = i_x - w_yShr;
      o_y = i_y + w_xShr;
      o_z = i_z - i_atan;
    end
  end

endmodule

// File: rtl/drom_atan.sv
// Iterative vectoring CORDIC: (re, im) -> 32-bit turn angle plus magnitude.
// Build option ATAN_MAG_COMP_EN divides the magnitude by the CORDIC gain.
module drom_atan
  import nco_pkg::*;
#(
  parameter int NITER = 16,
  parameter int XW    = 18
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] t_iq_dat,
  input  logic        t_iq_req,
  output logic        t_iq_ack,
  output logic [47:0] i_phase_dat,
  output logic        i_phase_req,
  input  logic        i_phase_ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [3:0] LAST_ITER = 4'(NITER - 1);

  logic [1:0]                r_state;
  logic [3:0]                r_cnt;
  logic signed [XW-1:0]      r_x;
  logic signed [XW-1:0]      r_y;
  logic [ANGLE_W-1:0]        r_z;
  logic                      r_zero;
  logic [47:0]               r_phaseDat;

  logic signed [XW-1:0]      w_reExt;
  logic signed [XW-1:0]      w_imExt;
  logic                      w_reNeg;
  logic signed [XW-1:0]      w_xInit;
  logic signed [XW-1:0]      w_yInit;
  logic [ANGLE_W-1:0]        w_zInit;
  logic                      w_isZero;
  logic [ANGLE_W-1:0]        w_atan;
  logic signed [XW-1:0]      w_xNext;
  logic signed [XW-1:0]      w_yNext;
  logic [ANGLE_W-1:0]        w_zNext;
  logic [15:0]               w_mag;
  logic [ANGLE_W-1:0]        w_angle;

  // Widen before negating so that re = -32768 maps to +32768 without wrapping.
  assign w_reExt  = {{(XW-SAMPLE_W){t_iq_dat[15]}}, t_iq_dat[15:0]};
  assign w_imExt  = {{(XW-SAMPLE_W){t_iq_dat[31]}}, t_iq_dat[31:16]};
  assign w_reNeg  = t_iq_dat[15];
  assign w_xInit  = w_reNeg ? -w_reExt : w_reExt;
  assign w_yInit  = w_reNeg ? -w_imExt : w_imExt;
  assign w_zInit  = w_reNeg ? 32'h8000_0000 : 32'h0000_0000;
  assign w_isZero = (t_iq_dat == 32'd0);
  assign w_atan   = ATAN_TABLE[r_cnt];

  atan_cordic_step #(.XW(XW)) u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_cnt),
    .i_atan  (w_atan),
    .o_x     (w_xNext),
    .o_y     (w_yNext),
    .o_z     (w_zNext)
  );

`ifdef ATAN_MAG_COMP_EN
  logic [XW+14:0] w_magProd;
  assign w_magProd = (XW+15)'($unsigned(w_xNext)) * (XW+15)'(KINV);
  assign w_mag     = 16'(w_magProd >> KINV_SHIFT);
`else
  assign w_mag = 16'(w_xNext >>> 1);
`endif

  // The all-zero input would otherwise accumulate the full table sum.
  assign w_angle = r_zero ? '0 : w_zNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_zero     <= 1'b0;
      r_phaseDat <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (t_iq_req) begin
            r_x     <= w_xInit;
            r_y     <= w_yInit;
            r_z     <= w_zInit;
            r_zero  <= w_isZero;
            r_cnt   <= '0;
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_x <= w_xNext;
          r_y <= w_yNext;
          r_z <= w_zNext;
          if (r_cnt == LAST_ITER) begin
            r_phaseDat <= {w_mag, w_angle};
            r_cnt      <= '0;
            r_state    <= ST_OUT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_OUT: begin
          if (i_phase_ack) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign t_iq_ack    = (r_state == ST_IDLE);
  assign i_phase_req = (r_state == ST_OUT);
  assign i_phase_dat = r_phaseDat;

endmodule

// File: tb/tb_drom_atan.sv
// Self-checking bench for drom_atan: directed corner vectors, handshake and
// reset behaviour, then an NCO round trip against a real-arithmetic atan2 model.
module tb_drom_atan;

  localparam int  NITER = 16;
  localparam real PI    = 3.14159265358979323846;
  localparam real TURN  = 4294967296.0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] t_iq_dat;
  logic        t_iq_req;
  logic        t_iq_ack;
  logic [47:0] i_phase_dat;
  logic        i_phase_req;
  logic        i_phase_ack;

  int testCount = 0;
  int failCount = 0;

  drom_atan #(.NITER(NITER), .XW(18)) dut (
    .clk         (clk),
    .reset       (reset),
    .t_iq_dat    (t_iq_dat),
    .t_iq_req    (t_iq_req),
    .t_iq_ack    (t_iq_ack),
    .i_phase_dat (i_phase_dat),
    .i_phase_req (i_phase_req),
    .i_phase_ack (i_phase_ack)
  );

  always #5 clk = ~clk;

  function automatic real cordicGain();
    real k = 1.0;
    real p = 1.0;
    for (int i = 0; i < NITER; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    return k;
  endfunction

  function automatic logic [31:0] refAngle(input int re, input int im);
    real t;
    longint lt;
    t = $atan2(real'(im), real'(re)) / (2.0 * PI) * TURN;
    if (t < 0.0) t = t + TURN;
    lt = longint'(t);
    return 32'(lt);
  endfunction

  function automatic real refMag(input int re, input int im);
    real r = $sqrt(real'(re) * real'(re) + real'(im) * real'(im));
`ifdef ATAN_MAG_COMP_EN
    return r * cordicGain() * 19898.0 / 32768.0;
`else
    return r * cordicGain() / 2.0;
`endif
  endfunction

  // The integer x/y datapath has no fraction bits, so a few LSB of truncation
  // on y turn into an angle error that scales with 1/|v| on top of the table residual.
  function automatic int angleTol(input int re, input int im);
    real r = $sqrt(real'(re) * real'(re) + real'(im) * real'(im));
    return 32768 + int'(6.0 * TURN / (2.0 * PI * r));
  endfunction

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
    end
  endtask

  task automatic checkWord(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%012h expected 0x%012h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int re, input int im,
                             input logic [31:0] expAngle, input bit exact);
    logic [31:0] gotAngle;
    int          angErr;
    int          gotMag;
    int          expMag;
    int          tolA;
    int          tolM;
    gotAngle = i_phase_dat[31:0];
    gotMag   = int'(i_phase_dat[47:32]);
    angErr   = int'(gotAngle - expAngle);
    if (angErr < 0) angErr = -angErr;
    expMag = exact ? 0 : int'(refMag(re, im));
    tolA   = exact ? 0 : angleTol(re, im);
    tolM   = exact ? 0 : 8;
    testCount++;
    assert (angErr <= tolA) else begin
      failCount++;
      $error("[TB] FAIL %s angle: observed 0x%08h expected 0x%08h (tol %0d)", tag, gotAngle, expAngle, tolA);
    end
    testCount++;
    assert ((gotMag - expMag <= tolM) && (expMag - gotMag <= tolM)) else begin
      failCount++;
      $error("[TB] FAIL %s mag: observed %0d expected %0d (tol %0d)", tag, gotMag, expMag, tolM);
    end
  endtask

  task automatic applyStimulus(input int re, input int im);
    int waitCycles = 0;
    t_iq_dat = {16'(im), 16'(re)};
    t_iq_req = 1'b1;
    while (t_iq_ack !== 1'b1 && waitCycles < 100) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkBit("accept_ready", t_iq_ack, 1'b1);
    @(posedge clk); #1;
    t_iq_req = 1'b0;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    while (i_phase_req !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    checkBit("result_timeout", i_phase_req, 1'b1);
  endtask

  task automatic ackResult();
    i_phase_ack = 1'b1;
    @(posedge clk); #1;
    i_phase_ack = 1'b0;
  endtask

  task automatic runVector(input string tag, input int re, input int im, input bit exact);
    int edges;
    applyStimulus(re, im);
    waitResult(edges);
    checkOutput(tag, re, im, exact ? 32'd0 : refAngle(re, im), exact);
    ackResult();
  endtask

  int          edges;
  logic [31:0] ph;
  real         phi;
  int          nRe;
  int          nIm;

  initial begin
    reset       = 1'b1;
    t_iq_dat    = '0;
    t_iq_req    = 1'b0;
    i_phase_ack = 1'b0;
    @(posedge clk); #1;
    checkBit("reset_t_iq_ack", t_iq_ack, 1'b1);
    checkBit("reset_i_phase_req", i_phase_req, 1'b0);
    checkWord("reset_i_phase_dat", i_phase_dat, 48'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Result appears after the accepting edge plus NITER iteration edges.
    applyStimulus(16384, 0);
    checkBit("iter_t_iq_ack_low", t_iq_ack, 1'b0);
    waitResult(edges);
    testCount++;
    assert (edges == NITER) else begin
      failCount++;
      $error("[TB] FAIL latency: observed %0d edges expected %0d", edges, NITER);
    end
    checkOutput("re_pos_axis", 16384, 0, 32'h0000_0000, 1'b0);
    ackResult();

    runVector("im_pos_axis", 0, 16384, 1'b0);
    runVector("diag_45", 11585, 11585, 1'b0);
    runVector("full_scale_neg", -32768, -32768, 1'b0);
    runVector("zero_input", 0, 0, 1'b1);

    // Backpressure with a new request already pending.
    applyStimulus(0, 16384);
    waitResult(edges);
    t_iq_dat = {16'(0), 16'(-16384)};
    t_iq_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkBit("bp_i_phase_req", i_phase_req, 1'b1);
      checkBit("bp_t_iq_ack", t_iq_ack, 1'b0);
      checkOutput("bp_hold", 0, 16384, 32'h4000_0000, 1'b0);
    end
    ackResult();
    checkBit("bp_idle_ack", t_iq_ack, 1'b1);
    checkBit("bp_idle_req", i_phase_req, 1'b0);
    @(posedge clk); #1;
    t_iq_req = 1'b0;
    checkBit("bp_pending_taken", t_iq_ack, 1'b0);
    waitResult(edges);
    checkOutput("re_neg_axis", -16384, 0, 32'h8000_0000, 1'b0);
    ackResult();

    // Reset while iterating, at cnt = 7.
    applyStimulus(0, -16384);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkBit("midreset_t_iq_ack", t_iq_ack, 1'b1);
    checkBit("midreset_i_phase_req", i_phase_req, 1'b0);
    checkWord("midreset_i_phase_dat", i_phase_dat, 48'd0);
    runVector("im_neg_axis", 0, -16384, 1'b0);

    // NCO round trip: quantised cos/sin of a random phase must return that phase.
    for (int k = 0; k < 256; k++) begin
      ph  = $urandom;
      phi = real'(ph) / TURN * 2.0 * PI;
      nRe = int'(32767.0 * $cos(phi));
      nIm = int'(32767.0 * $sin(phi));
      applyStimulus(nRe, nIm);
      waitResult(edges);
      checkOutput("nco_round_trip", nRe, nIm, ph, 1'b0);
      ackResult();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
